// File: rtl/rdm_pkg.sv
// Shared definitions for the rdm_req/rdm8 random-byte interface,
// imported by the byte server and by the cmp-side consumers.
package rdm_pkg;

    localparam int RDM_WORD_W = 64;
    localparam int RDM_BYTE_W = 8;

    typedef enum logic {
        PRIME = 1'b0,
        SERVE = 1'b1
    } rdm_srv_st_e;

endpackage

// File: rtl/rdm_ring.sv
// Byte ring for the random-byte server: one 64-bit word written per cycle,
// one byte read combinationally. The storage is intentionally not reset.
module rdm_ring
    import rdm_pkg::*;
#(
    parameter int DEPTH_W = 4
) (
    input  logic                            clk,
    input  logic                            we_i,
    input  logic [$clog2(DEPTH_W)-1:0]      wr_ptr_i,
    input  logic [RDM_WORD_W-1:0]           wdata_i,
    input  logic [$clog2(DEPTH_W*8)-1:0]    rd_ptr_i,
    output logic [RDM_BYTE_W-1:0]           rdata_o
);

    localparam int CAP = DEPTH_W * 8;
    localparam int BPW = RDM_WORD_W / RDM_BYTE_W;

    logic [RDM_BYTE_W-1:0] mem_q [CAP];

    // Byte k of the word lands in slot wr_ptr*8+k, so word_in[7:0] is served first.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int k = 0; k < BPW; k++) begin
                mem_q[{wr_ptr_i, 3'(k)}] <= wdata_i[RDM_BYTE_W*k +: RDM_BYTE_W];
            end
        end
    end

    assign rdata_o = mem_q[rd_ptr_i];

endmodule

// File: rtl/rdm_byte_srv.sv
// Random-byte server: buffers 64-bit PRNG words and serves one byte per
// rdm_req with zero latency. Optional counters under RDM_SRV_STATS_EN.
//
//  state | meaning
//  PRIME | filling after reset/flush/underflow; rdm_ready low (requests still served if level>0)
//  SERVE | primed; rdm_ready high until underflow or flush
module rdm_byte_srv
    import rdm_pkg::*;
#(
    parameter int DEPTH_W = 4,
    parameter int PRIME_B = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic [RDM_WORD_W-1:0]           word_in,
    input  logic                            word_valid,
    output logic                            word_ready,
    input  logic                            rdm_req,
    output logic [RDM_BYTE_W-1:0]           rdm8,
    output logic                            rdm_ready,
    output logic [$clog2(DEPTH_W*8):0]      level,
    output logic                            underflow
`ifdef RDM_SRV_STATS_EN
    ,
    output logic [31:0]                     stat_bytes,
    output logic [15:0]                     stat_stall
`endif
);

    localparam int CAP   = DEPTH_W * 8;
    localparam int LVL_W = $clog2(CAP) + 1;
    localparam int RP_W  = $clog2(CAP);
    localparam int WP_W  = $clog2(DEPTH_W);
    localparam logic [LVL_W-1:0] WR_LIMIT  = LVL_W'(CAP - 8);
    localparam logic [LVL_W-1:0] PRIME_LVL = LVL_W'(PRIME_B);

    rdm_srv_st_e             state_q, state_d;
    logic [LVL_W-1:0]        level_q, level_d;
    logic [RP_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [WP_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic                    uflow_q, uflow_d;
    logic                    empty, push, pop, uf_evt;
    logic [RDM_BYTE_W-1:0]   head;

    // word_ready depends only on registered level and flush, never on rdm_req.
    assign empty      = (level_q == '0);
    assign word_ready = (level_q <= WR_LIMIT) && !flush;
    assign push       = word_valid && word_ready;
    assign pop        = rdm_req && !empty && !flush;
    assign uf_evt     = rdm_req && empty && !flush;

    rdm_ring #(.DEPTH_W(DEPTH_W)) u_ring (
        .clk      (clk),
        .we_i     (push),
        .wr_ptr_i (wr_ptr_q),
        .wdata_i  (word_in),
        .rd_ptr_i (rd_ptr_q),
        .rdata_o  (head)
    );

    always_comb begin
        level_d  = level_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        uflow_d  = uflow_q;
        if (flush) begin
            level_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            uflow_d  = 1'b0;
        end else begin
            if (push) begin
                level_d  = level_d + LVL_W'(8);
                wr_ptr_d = wr_ptr_q + WP_W'(1);
            end
            if (pop) begin
                level_d  = level_d - LVL_W'(1);
                rd_ptr_d = rd_ptr_q + RP_W'(1);
            end
            if (uf_evt) begin
                uflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            uflow_q  <= 1'b0;
        end else begin
            level_q  <= level_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            uflow_q  <= uflow_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PRIME;
        end else begin
            state_q <= state_d;
        end
    end

    // Entry uses the next-cycle level so rdm_ready rises together with the priming byte count.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PRIME: if (!flush && !uf_evt && level_d >= PRIME_LVL) state_d = SERVE;
            SERVE: if (flush || uf_evt) state_d = PRIME;
        endcase
    end

    always_comb begin
        rdm_ready = (state_q == SERVE);
    end

    assign rdm8      = empty ? '0 : head;
    assign level     = level_q;
    assign underflow = uflow_q;

`ifdef RDM_SRV_STATS_EN
    logic [31:0] sbytes_q;
    logic [15:0] sstall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbytes_q <= '0;
            sstall_q <= '0;
        end else if (flush) begin
            sbytes_q <= '0;
            sstall_q <= '0;
        end else begin
            if (pop && sbytes_q != '1) sbytes_q <= sbytes_q + 32'd1;
            if (word_valid && !word_ready && sstall_q != '1) sstall_q <= sstall_q + 16'd1;
        end
    end

    assign stat_bytes = sbytes_q;
    assign stat_stall = sstall_q;
`endif

endmodule
